// File: rtl/cve2_register_file_mp.sv
// Multi-port FPGA register file for cve2, with a sequential clear engine that initialises the RAM.
// Optional per-word even parity with read checking when CVE2_RF_PARITY_EN is defined.
//
// state  | meaning
// CLEAR  | clear engine writes WordZeroVal to x1..xN; port writes dropped, reads return WordZeroVal
// READY  | normal operation; ready_o high
module cve2_register_file_mp #(
    parameter bit                   RV32E         = 1'b0,
    parameter int unsigned          DataWidth     = 32,
    parameter logic [DataWidth-1:0] WordZeroVal   = '0,
    parameter int unsigned          NumReadPorts  = 2,
    parameter int unsigned          NumWritePorts = 1,
    parameter bit                   WriteBypass   = 1'b0
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReadPorts*5-1:0]           raddr_i,
    output logic [NumReadPorts*DataWidth-1:0]   rdata_o,
    input  logic [NumWritePorts*5-1:0]          waddr_i,
    input  logic [NumWritePorts*DataWidth-1:0]  wdata_i,
    input  logic [NumWritePorts-1:0]            we_i,
    input  logic                                clear_req_i,
    output logic                                ready_o,
    output logic                                err_o
);

    localparam int unsigned NumWords = RV32E ? 16 : 32;
    localparam int unsigned AddrW    = RV32E ? 4 : 5;
    localparam logic [AddrW-1:0] LastIdx = AddrW'(NumWords - 1);

`ifdef CVE2_RF_PARITY_EN
    localparam int unsigned MemW = DataWidth + 1;
`else
    localparam int unsigned MemW = DataWidth;
`endif

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StReady = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [AddrW-1:0] clr_cnt_q, clr_cnt_d;
    logic             in_ready;

    // Distributed RAM: no reset, the clear engine is the only initialisation path.
    logic [MemW-1:0]  mem [NumWords];

    function automatic logic [MemW-1:0] encode(input logic [DataWidth-1:0] d);
`ifdef CVE2_RF_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    assign in_ready = (state_q == StReady);
    assign ready_o  = in_ready;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + AddrW'(1);
                if (clr_cnt_q == LastIdx) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (clear_req_i) begin
                    state_d   = StClear;
                    clr_cnt_d = AddrW'(1);
                end
            end
            default: begin
                state_d   = StClear;
                clr_cnt_d = AddrW'(1);
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StClear;
            clr_cnt_q <= AddrW'(1);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    logic [NumWritePorts-1:0] wvalid;

    for (genvar w = 0; w < NumWritePorts; w++) begin : g_wr
        assign wvalid[w] = in_ready && we_i[w] && (waddr_i[5*w +: 5] != 5'd0) &&
                           (!RV32E || !waddr_i[5*w+4]);
    end

    // Later write ports override earlier ones on an address collision.
    always_ff @(posedge clk_i) begin
        if (!in_ready) begin
            mem[clr_cnt_q] <= encode(WordZeroVal);
        end else begin
            for (int w = 0; w < NumWritePorts; w++) begin
                if (wvalid[w]) begin
                    mem[waddr_i[5*w +: AddrW]] <= encode(wdata_i[DataWidth*w +: DataWidth]);
                end
            end
        end
    end

`ifdef CVE2_RF_PARITY_EN
    logic [NumReadPorts-1:0] rd_err;
`endif

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
        logic [4:0]           ra;
        logic                 ra_valid;
        logic                 byp_hit;
        logic [DataWidth-1:0] byp_data;
        logic [MemW-1:0]      word;

        assign ra       = raddr_i[5*p +: 5];
        assign ra_valid = (ra != 5'd0) && (!RV32E || !ra[4]);
        assign word     = mem[ra[AddrW-1:0]];

        always_comb begin
            byp_hit  = 1'b0;
            byp_data = '0;
            if (WriteBypass) begin
                for (int w = 0; w < NumWritePorts; w++) begin
                    if (wvalid[w] && (waddr_i[5*w +: 5] == ra)) begin
                        byp_hit  = 1'b1;
                        byp_data = wdata_i[DataWidth*w +: DataWidth];
                    end
                end
            end
        end

        always_comb begin
            rdata_o[DataWidth*p +: DataWidth] = '0;
            if (!in_ready) begin
                if (ra != 5'd0) begin
                    rdata_o[DataWidth*p +: DataWidth] = WordZeroVal;
                end
            end else if (ra_valid) begin
                if (byp_hit) begin
                    rdata_o[DataWidth*p +: DataWidth] = byp_data;
                end else begin
                    rdata_o[DataWidth*p +: DataWidth] = word[DataWidth-1:0];
                end
            end
        end

`ifdef CVE2_RF_PARITY_EN
        // Stored word includes its parity bit, so a clean word XORs to zero.
        assign rd_err[p] = in_ready && ra_valid && !byp_hit && (^word);
`endif
    end

`ifdef CVE2_RF_PARITY_EN
    assign err_o = |rd_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cve2_register_file_mp.sv
// Bench for cve2_register_file_mp: a 32-entry 2W/bypass instance and a 16-entry 1W/no-bypass instance.
module tb_cve2_register_file_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0]  raddr_a = '0;
    logic [63:0] rdata_a;
    logic [9:0]  waddr_a = '0;
    logic [63:0] wdata_a = '0;
    logic [1:0]  we_a = '0;
    logic        clr_a = 1'b0;
    logic        ready_a, err_a;

    logic [9:0]  raddr_b = '0;
    logic [63:0] rdata_b;
    logic [4:0]  waddr_b = '0;
    logic [31:0] wdata_b = '0;
    logic [0:0]  we_b = '0;
    logic        clr_b = 1'b0;
    logic        ready_b, err_b;

    cve2_register_file_mp #(
        .RV32E(1'b0), .DataWidth(32), .WordZeroVal(32'hDEAD_BEEF),
        .NumReadPorts(2), .NumWritePorts(2), .WriteBypass(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr_a), .rdata_o(rdata_a),
        .waddr_i(waddr_a), .wdata_i(wdata_a), .we_i(we_a), .clear_req_i(clr_a),
        .ready_o(ready_a), .err_o(err_a)
    );

    cve2_register_file_mp #(
        .RV32E(1'b1), .DataWidth(32), .WordZeroVal(32'h0BAD_F00D),
        .NumReadPorts(2), .NumWritePorts(1), .WriteBypass(1'b0)
    ) dut_e (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr_b), .rdata_o(rdata_b),
        .waddr_i(waddr_b), .wdata_i(wdata_b), .we_i(we_b), .clear_req_i(clr_b),
        .ready_o(ready_b), .err_o(err_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1;
        logic [31:0] exp0, exp1;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // Each row: drive writes and reads together, check reads before the edge, then clock.
        vecs[0]  = '{2'b01, 5'd3,  5'd0,  32'h1234_5678, 32'h0,         5'd3,  5'd0,  32'h1234_5678, 32'h0};
        vecs[1]  = '{2'b00, 5'd0,  5'd0,  32'h0,         32'h0,         5'd3,  5'd0,  32'h1234_5678, 32'h0};
        vecs[2]  = '{2'b11, 5'd7,  5'd7,  32'hAAAA_0000, 32'h5555_0000, 5'd7,  5'd5,  32'h5555_0000, 32'hDEAD_BEEF};
        vecs[3]  = '{2'b00, 5'd0,  5'd0,  32'h0,         32'h0,         5'd7,  5'd3,  32'h5555_0000, 32'h1234_5678};
        vecs[4]  = '{2'b01, 5'd9,  5'd0,  32'hCAFE_F00D, 32'h0,         5'd9,  5'd9,  32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[5]  = '{2'b10, 5'd0,  5'd0,  32'h0,         32'hFFFF_FFFF, 5'd0,  5'd9,  32'h0,         32'hCAFE_F00D};
        vecs[6]  = '{2'b00, 5'd0,  5'd0,  32'h0,         32'h0,         5'd0,  5'd31, 32'h0,         32'hDEAD_BEEF};
        vecs[7]  = '{2'b11, 5'd31, 5'd30, 32'h1111_1111, 32'h2222_2222, 5'd30, 5'd31, 32'h2222_2222, 32'h1111_1111};
        vecs[8]  = '{2'b00, 5'd0,  5'd0,  32'h0,         32'h0,         5'd31, 5'd30, 32'h1111_1111, 32'h2222_2222};
        vecs[9]  = '{2'b01, 5'd3,  5'd0,  32'h0,         32'h0,         5'd1,  5'd3,  32'hDEAD_BEEF, 32'h0};
        vecs[10] = '{2'b00, 5'd0,  5'd0,  32'h0,         32'h0,         5'd3,  5'd2,  32'h0,         32'hDEAD_BEEF};

        // Reset state and reads during clear
        raddr_a = {5'd0, 5'd5};
        #12;
        check("reset ready_a", {31'b0, ready_a}, 32'h0);
        check("reset err_a", {31'b0, err_a}, 32'h0);
        check("reset ready_b", {31'b0, ready_b}, 32'h0);
        check("clear read x5", rdata_a[31:0], 32'hDEAD_BEEF);
        check("clear read x0", rdata_a[63:32], 32'h0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        we_b = 1'b1;
        waddr_b = 5'd6;
        wdata_b = 32'h7777_7777;
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (i == 14) check("rv32e ready low at 14", {31'b0, ready_b}, 32'h0);
            if (i == 15) begin
                check("rv32e ready high at 15", {31'b0, ready_b}, 32'h1);
                we_b = 1'b0;
            end
            if (i == 30) check("ready low at 30", {31'b0, ready_a}, 32'h0);
        end
        check("ready high at 31", {31'b0, ready_a}, 32'h1);
        raddr_a = {5'd0, 5'd5};
        #1;
        check("ready read x5", rdata_a[31:0], 32'hDEAD_BEEF);
        check("ready read x0", rdata_a[63:32], 32'h0);

        for (int i = 0; i < 11; i++) begin
            we_a    = vecs[i].we;
            waddr_a = {vecs[i].wa1, vecs[i].wa0};
            wdata_a = {vecs[i].wd1, vecs[i].wd0};
            raddr_a = {vecs[i].ra1, vecs[i].ra0};
            #1;
            check($sformatf("vec%0d port0", i), rdata_a[31:0], vecs[i].exp0);
            check($sformatf("vec%0d port1", i), rdata_a[63:32], vecs[i].exp1);
            check($sformatf("vec%0d err", i), {31'b0, err_a}, 32'h0);
            tick();
        end
        we_a = '0;

        // No-bypass instance: same-cycle read sees old data, out-of-range write ignored
        we_b = 1'b1;
        waddr_b = 5'd9;
        wdata_b = 32'hCAFE_F00D;
        raddr_b = {5'd6, 5'd9};
        #1;
        check("nobyp same cycle x9", rdata_b[31:0], 32'h0BAD_F00D);
        check("clear write dropped x6", rdata_b[63:32], 32'h0BAD_F00D);
        tick();
        waddr_b = 5'd20;
        wdata_b = 32'h1234_5678;
        #1;
        check("nobyp next cycle x9", rdata_b[31:0], 32'hCAFE_F00D);
        tick();
        we_b = 1'b0;
        raddr_b = {5'd4, 5'd20};
        #1;
        check("rv32e read x20", rdata_b[31:0], 32'h0);
        check("rv32e no alias x4", rdata_b[63:32], 32'h0BAD_F00D);
        check("rv32e err", {31'b0, err_b}, 32'h0);

`ifdef CVE2_RF_PARITY_EN
        dut_e.mem[2][0] = ~dut_e.mem[2][0];
        raddr_b = {5'd0, 5'd2};
        #1;
        check("parity err x2", {31'b0, err_b}, 32'h1);
        tick();
        raddr_b = {5'd0, 5'd3};
        #1;
        check("parity clean x3", {31'b0, err_b}, 32'h0);
`endif

        // Clear request: write x4 first, then a write during clear must be dropped
        we_a = 2'b01;
        waddr_a = {5'd0, 5'd4};
        wdata_a = {32'h0, 32'h0000_0001};
        tick();
        we_a = '0;
        raddr_a = {5'd0, 5'd4};
        #1;
        check("x4 before clear", rdata_a[31:0], 32'h0000_0001);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("clear ready low", {31'b0, ready_a}, 32'h0);
        check("clear read x4", rdata_a[31:0], 32'hDEAD_BEEF);
        for (int i = 1; i <= 31; i++) begin
            if (i == 20) begin
                we_a = 2'b01;
                waddr_a = {5'd0, 5'd4};
                wdata_a = {32'h0, 32'h4444_4444};
            end
            if (i == 21) we_a = '0;
            tick();
            if (i == 30) check("clear ready low at 30", {31'b0, ready_a}, 32'h0);
        end
        check("clear ready high at 31", {31'b0, ready_a}, 32'h1);
        raddr_a = {5'd3, 5'd4};
        #1;
        check("x4 after clear", rdata_a[31:0], 32'hDEAD_BEEF);
        check("x3 after clear", rdata_a[63:32], 32'hDEAD_BEEF);

        // Reset during clear restarts from counter 1
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #2;
        check("midclear reset ready", {31'b0, ready_a}, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (i == 30) check("restart ready low at 30", {31'b0, ready_a}, 32'h0);
        end
        check("restart ready high at 31", {31'b0, ready_a}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
